// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  // Sequencer states: normal issue, data-memory wait, debug drain, debug park, single step.
  typedef enum logic [2:0] {
    StRun,
    StMemWait,
    StHalting,
    StHalted,
    StStep
  } state_e;

  // Bubble cycles needed to empty ID..WB after a halt is accepted.
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  // addi x0,x0,0 -- the bubble loaded by pipeline registers on flush.
  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: datapath/debug requests in, PC/pipeline-register strobes out.
// Perf counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if;

  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_MemRead;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        dbg_halt_req;
  logic        dbg_step;
  logic        dbg_resume;

  logic        PC_write;
  logic        IF_ID_stall;
  logic        ID_EX_stall;
  logic        EX_MEM_stall;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        EX_MEM_flush;
  logic        MEM_WB_flush;
  logic        halted;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] memwait_cnt;
`endif

  // Controller side.
  modport master (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead, ex_redirect,
    input  mem_req, mem_ready, dbg_halt_req, dbg_step, dbg_resume,
    output PC_write, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
    output IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, halted
`ifdef PIPE_PERF_CNT_EN
    , output stall_cnt, flush_cnt, memwait_cnt
`endif
  );

  // Datapath / debug-module side.
  modport slave (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead, ex_redirect,
    output mem_req, mem_ready, dbg_halt_req, dbg_step, dbg_resume,
    input  PC_write, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
    input  IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, halted
`ifdef PIPE_PERF_CNT_EN
    , input stall_cnt, flush_cnt, memwait_cnt
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: a load in EX writes a register the ID instruction reads.
module load_use_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real dependency.
  always_comb begin
    rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, redirect, load-use and
// debug halt/step. Optional perf counters under PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.master hz
);

  localparam int unsigned CntW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   drain_q, drain_d, drain_inc;
  logic              pend_q, pend_d;

  logic              mem_stall;
  logic              load_use;
  logic              pc_write, if_id_stall, id_ex_stall, ex_mem_stall;
  logic              if_id_flush, id_ex_flush, mem_wb_flush;

  assign mem_stall = hz.mem_req && !hz.mem_ready;
  assign drain_inc = drain_q + CntW'(1);

  load_use_detect u_load_use_detect (
    .id_rs1_i      (hz.id_rs1),
    .id_rs2_i      (hz.id_rs2),
    .id_use_rs1_i  (hz.id_use_rs1),
    .id_use_rs2_i  (hz.id_use_rs2),
    .ex_rd_i       (hz.ex_rd),
    .ex_mem_read_i (hz.ex_MemRead),
    .load_use_o    (load_use)
  );

  // State, drain counter and pending-halt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      drain_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pend_d  = pend_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
          pend_d  = hz.dbg_halt_req;
        end else if (hz.dbg_halt_req) begin
          state_d = StHalting;
          drain_d = '0;
        end
      end
      StMemWait: begin
        if (hz.dbg_halt_req) pend_d = 1'b1;
        // Leave once memory completes (or the request was withdrawn).
        if (!mem_stall) begin
          state_d = (pend_q || hz.dbg_halt_req) ? StHalting : StRun;
          pend_d  = 1'b0;
          drain_d = '0;
        end
      end
      StHalting: begin
        if (hz.dbg_resume) begin
          state_d = StRun;
        end else if (!mem_stall) begin
          // Only cycles that actually advance the pipeline count toward the drain.
          if (drain_inc == CntW'(DRAIN_CYCLES)) begin
            state_d = StHalted;
            drain_d = '0;
          end else begin
            drain_d = drain_inc;
          end
        end
      end
      StHalted: begin
        if (hz.dbg_resume)    state_d = StRun;
        else if (hz.dbg_step) state_d = StStep;
      end
      StStep: begin
        if (!mem_stall) begin
          state_d = StHalting;
          drain_d = '0;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Prioritised control strobes: memory stall > redirect > load-use > debug bubble.
  always_comb begin
    pc_write     = 1'b1;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      pc_write = 1'b0;
    end else if (mem_stall) begin
      // Freeze IF..EX (redirect stays held in EX) and bubble into WB.
      pc_write     = 1'b0;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (hz.ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == StHalting || state_q == StHalted) begin
      pc_write    = 1'b0;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign hz.PC_write     = pc_write;
  assign hz.IF_ID_stall  = if_id_stall;
  assign hz.ID_EX_stall  = id_ex_stall;
  assign hz.EX_MEM_stall = ex_mem_stall;
  assign hz.IF_ID_flush  = if_id_flush;
  assign hz.ID_EX_flush  = id_ex_flush;
  assign hz.EX_MEM_flush = 1'b0; // reserved for exceptions
  assign hz.MEM_WB_flush = mem_wb_flush;
  assign hz.halted       = (state_q == StHalted);

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (!pc_write && state_q != StHalted) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush)                      flush_cnt_q <= flush_cnt_q + 32'd1;
      if (mem_stall)                        memwait_cnt_q <= memwait_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;
  assign hz.memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  // {PC_write, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
  //  IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, halted}
  localparam logic [8:0] E_ZERO = 9'b000000000;
  localparam logic [8:0] E_RUN  = 9'b100000000;
  localparam logic [8:0] E_BUB  = 9'b010001000;
  localparam logic [8:0] E_RDR  = 9'b100011000;
  localparam logic [8:0] E_MST  = 9'b011100010;
  localparam logic [8:0] E_HLT  = 9'b010001001;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz_if ();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz_if.id_rs1       = 5'd0;
    hz_if.id_rs2       = 5'd0;
    hz_if.id_use_rs1   = 1'b0;
    hz_if.id_use_rs2   = 1'b0;
    hz_if.ex_rd        = 5'd0;
    hz_if.ex_MemRead   = 1'b0;
    hz_if.ex_redirect  = 1'b0;
    hz_if.mem_req      = 1'b0;
    hz_if.mem_ready    = 1'b0;
    hz_if.dbg_halt_req = 1'b0;
    hz_if.dbg_step     = 1'b0;
    hz_if.dbg_resume   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    #1;
    obs = {hz_if.PC_write, hz_if.IF_ID_stall, hz_if.ID_EX_stall, hz_if.EX_MEM_stall,
           hz_if.IF_ID_flush, hz_if.ID_EX_flush, hz_if.EX_MEM_flush, hz_if.MEM_WB_flush,
           hz_if.halted};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    idle();
    rst = 1'b1;
    tick();
    check("rst_outputs", E_ZERO);
    tick();
    rst = 1'b0;
    check("post_reset", E_RUN);

    // Load x5 in EX, add x6,x5,x1 in ID.
    tick();
    hz_if.ex_MemRead = 1'b1; hz_if.ex_rd = 5'd5;
    hz_if.id_rs1 = 5'd5; hz_if.id_use_rs1 = 1'b1;
    hz_if.id_rs2 = 5'd1; hz_if.id_use_rs2 = 1'b1;
    check("lu_rs1", E_BUB);
    tick();
    hz_if.ex_MemRead = 1'b0; hz_if.ex_rd = 5'd6;
    check("lu_one_cycle", E_RUN);

    tick();
    idle();
    hz_if.ex_MemRead = 1'b1; hz_if.ex_rd = 5'd0;
    hz_if.id_rs1 = 5'd0; hz_if.id_use_rs1 = 1'b1;
    check("x0_no_stall", E_RUN);
    tick();
    hz_if.ex_rd = 5'd7; hz_if.id_rs1 = 5'd3;
    hz_if.id_rs2 = 5'd7; hz_if.id_use_rs2 = 1'b0;
    check("rs2_unused", E_RUN);
    hz_if.id_use_rs2 = 1'b1;
    check("lu_rs2", E_BUB);
    hz_if.ex_redirect = 1'b1;
    check("redir_over_lu", E_RDR);

    // Three-cycle memory wait with a redirect held in EX.
    tick();
    idle();
    hz_if.mem_req = 1'b1; hz_if.ex_redirect = 1'b1;
    check("mw_1", E_MST);
    tick();
    check("mw_2", E_MST);
    tick();
    check("mw_3", E_MST);
    tick();
    hz_if.mem_ready = 1'b1;
    check("mw_redirect", E_RDR);
    tick();
    idle();
    check("mw_done", E_RUN);

    // Halt, ignored re-halt, single step, resume beating step.
    tick();
    hz_if.dbg_halt_req = 1'b1;
    check("halt_req_cycle", E_RUN);
    for (int i = 0; i < 3; i++) begin
      tick();
      hz_if.dbg_halt_req = 1'b0;
      check("halt_drain", E_BUB);
    end
    tick();
    check("halted", E_HLT);
    hz_if.dbg_halt_req = 1'b1;
    check("halt_in_halted", E_HLT);
    tick();
    hz_if.dbg_halt_req = 1'b0;
    check("still_halted", E_HLT);
    hz_if.dbg_step = 1'b1;
    check("step_req", E_HLT);
    tick();
    hz_if.dbg_step = 1'b0;
    check("step_cycle", E_RUN);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("step_drain", E_BUB);
    end
    tick();
    check("rehalted", E_HLT);
    hz_if.dbg_resume = 1'b1; hz_if.dbg_step = 1'b1;
    check("resume_req", E_HLT);
    tick();
    idle();
    check("resumed", E_RUN);
    tick();
    check("resumed_2", E_RUN);

    // Redirect honoured mid-drain; drain still advances.
    hz_if.dbg_halt_req = 1'b1;
    check("halt2_req", E_RUN);
    tick();
    hz_if.dbg_halt_req = 1'b0;
    check("halt2_drain1", E_BUB);
    tick();
    hz_if.ex_redirect = 1'b1;
    check("halting_redirect", E_RDR);
    tick();
    hz_if.ex_redirect = 1'b0;
    check("halt2_drain3", E_BUB);
    tick();
    check("halt2_halted", E_HLT);
    hz_if.dbg_resume = 1'b1;
    tick();
    hz_if.dbg_resume = 1'b0;
    check("halt2_resumed", E_RUN);

    // Halt request latched while waiting on memory.
    hz_if.mem_req = 1'b1;
    check("hmw_stall", E_MST);
    tick();
    hz_if.dbg_halt_req = 1'b1;
    check("hmw_req", E_MST);
    tick();
    hz_if.dbg_halt_req = 1'b0; hz_if.mem_ready = 1'b1;
    check("hmw_exit", E_RUN);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      check("hmw_drain", E_BUB);
      tick();
    end
    check("hmw_halted", E_HLT);
    hz_if.dbg_resume = 1'b1;
    tick();
    idle();
    check("hmw_resumed", E_RUN);

    // Reset while in memory wait.
    hz_if.mem_req = 1'b1;
    check("rmw_stall", E_MST);
    tick();
    rst = 1'b1;
    check("rmw_rst_gate", E_ZERO);
    tick();
    rst = 1'b0; hz_if.mem_req = 1'b0;
    check("rmw_after_rst", E_RUN);

`ifdef PIPE_PERF_CNT_EN
    check32("stall_cnt_rst", hz_if.stall_cnt, 32'd0);
    check32("flush_cnt_rst", hz_if.flush_cnt, 32'd0);
    check32("memwait_cnt_rst", hz_if.memwait_cnt, 32'd0);
    hz_if.ex_MemRead = 1'b1; hz_if.ex_rd = 5'd9;
    hz_if.id_rs1 = 5'd9; hz_if.id_use_rs1 = 1'b1;
    tick();
    idle();
    check32("stall_cnt_lu", hz_if.stall_cnt, 32'd1);
    hz_if.ex_redirect = 1'b1;
    tick();
    idle();
    check32("flush_cnt_rd", hz_if.flush_cnt, 32'd1);
    hz_if.mem_req = 1'b1;
    tick();
    hz_if.mem_ready = 1'b1;
    #1;
    check32("memwait_cnt_mw", hz_if.memwait_cnt, 32'd1);
    check32("stall_cnt_mw", hz_if.stall_cnt, 32'd2);
    tick();
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline CPU. It combines load-use hazard detection, EX-stage control-flow redirects, data-memory wait handshakes and a debug halt/single-step state machine. From these it generates PC write-enable and per-register hold/flush strobes for IF/ID, ID/EX, EX/MEM and MEM/WB. It sits beside the datapath in the CPU top level and is the only source of those control signals.

## Interface
- DRAIN_CYCLES, 3: bubble cycles after a halt is accepted before `halted` asserts (enough to empty ID..WB).
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_MemRead  in  1  the EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch or jump, and the PC mux selects the target
- mem_req  in  1  the MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- dbg_halt_req, dbg_step, dbg_resume  in  1 each  debug commands, each a one-cycle pulse
- PC_write  out  1  PC register load enable
- IF_ID_stall, ID_EX_stall, EX_MEM_stall  out  1 each  hold the register's contents
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load a NOP/bubble (flush beats stall in the register)
- halted  out  1  the core is halted and drained
- stall_cnt, flush_cnt, memwait_cnt  out  32 each  present only under PIPE_PERF_CNT_EN

## Operation
- States: RUN, MEM_WAIT, HALTING, HALTED, STEP.
- Control outputs are combinational from state and inputs. State, drain counter and perf counters are registered.
- Output priority, evaluated each cycle:
  1. **Memory stall.** Applies when `mem_req && !mem_ready`.
     - PC_write=0.
     - IF_ID_stall, ID_EX_stall and EX_MEM_stall are 1.
     - MEM_WB_flush=1.
     - Nothing else asserts; any redirect is held in EX and re-evaluated next cycle.
  2. **Redirect.** Applies when `ex_redirect`: PC_write=1, IF_ID_flush=1, ID_EX_flush=1.
  3. **Load-use hazard.** Applies when `ex_MemRead && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))`: PC_write=0, IF_ID_stall=1, ID_EX_flush=1.
  4. **Halting/halted, no STEP.** PC_write=0, IF_ID_stall=1, ID_EX_flush=1 (bubble injection).
  5. **Otherwise.** PC_write=1 and all holds and flushes are 0.
- EX_MEM_flush is reserved for exceptions and is tied to 0 in this revision.
- Transitions:
  - RUN→MEM_WAIT when the memory stall is active.
  - MEM_WAIT→RUN, or →HALTING if a halt is pending, on `mem_ready`.
  - RUN→HALTING on `dbg_halt_req`. A request that arrives during MEM_WAIT is latched as pending.
  - HALTING counts non-memory-stalled cycles. It moves to HALTED when the count reaches DRAIN_CYCLES.
  - HALTED→STEP on `dbg_step`.
  - STEP lasts one cycle with RUN outputs, then returns to HALTING with the drain count reset. A memory stall in that cycle extends STEP until `mem_ready`.
  - HALTED or HALTING→RUN on `dbg_resume`. Resume beats step in the same cycle.
- `halted` = (state==HALTED).
- `dbg_halt_req` in HALTED/HALTING is ignored. `dbg_step` and `dbg_resume` in RUN are ignored.

## Timing
- Reset: state=RUN, drain count=0, pending halt=0, halted=0, perf counters=0.
- While rst is high, PC_write=0 and all stall/flush outputs are 0.
- Stall and flush outputs take effect on the same cycle as their causing input, with zero latency.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM and forwarding resolves the hazard.
- A redirect costs 2 bubbles.
- A memory wait of N cycles (mem_ready low for N cycles) freezes the pipeline for exactly N cycles.
- Halt latency: `halted` rises DRAIN_CYCLES+1 cycles after `dbg_halt_req`, plus any memory-wait cycles.
- Redirects arriving during HALTING are honoured normally. The drain counter still advances.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - stall_cnt increments on cycles with PC_write=0 outside HALTED.
  - flush_cnt increments on cycles with IF_ID_flush=1.
  - memwait_cnt increments on memory-stall cycles.
  - All three wrap modulo 2^32 and are cleared by rst.
- `PIPE_PERF_CNT_EN` undefined: the counters and their ports are absent.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum;
  - `DRAIN_CYCLES_DEF`;
  - the NOP encoding `32'h00000013`, shared with the pipeline registers.
- Sub-module `load_use_detect` is the purely combinational register-compare for priority 3.

## Test plan
- **Load-use.** Load x5 in EX, `add x6,x5,x1` in ID → exactly 1 cycle with PC_write=0, IF_ID_stall=1, ID_EX_flush=1.
- **No false stall.**
  - Load with ex_rd=0 and id_rs1=0 → no stall.
  - ex_rd=7 with id_use_rs2=0 and id_rs2=7 → no stall.
- **Redirect vs load-use.** ex_redirect=1 and load-use asserted together → PC_write=1, IF_ID_flush=1, ID_EX_flush=1, IF_ID_stall=0.
- **Memory wait.** mem_req=1 with mem_ready low 3 cycles, plus a simultaneous redirect → 3 frozen cycles with MEM_WB_flush=1, then the redirect takes effect on the 4th cycle.
- **Halt/step/resume.** halt pulse → halted=1 after 4 cycles. A step gives 1 cycle of PC_write=1 and halted re-rises 4 cycles later. resume → RUN.
- **Reset mid-MEM_WAIT.** rst for 1 cycle → state RUN, halted=0, counters 0, PC_write=1 on the first cycle after reset.
